// File: rtl/video_cfg_pkg.sv
// video_cfg_pkg: shared types and width helper for the video config sequencer
package video_cfg_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_VS, BLANK, APPLY, SETTLE} state_t;
  typedef struct packed {
    logic [2:0]  preset;
    logic [31:0] sw;
    logic        gray;
  } video_cfg_t;
  localparam int PRESET_W = 3;
  localparam int SW_W = 32;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/video_cfg_sequencer_frame_event_gen.sv
// frame_event_gen: VSync rising-edge detect with a no-VSync timeout fallback
module frame_event_gen
  import video_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk_vid,
  input  logic reset,
  input  logic core_vs,
  input  logic run,
  output logic frame_evt
);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  logic          vs_q;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  assign timeout = to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign frame_evt = (core_vs & ~vs_q) | timeout;
  // edge-detect register and timeout counter, idle-cleared and restarted on every event
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      vs_q   <= 1'b0;
      to_cnt <= '0;
    end else begin
      vs_q   <= core_vs;
      to_cnt <= (!run || frame_evt) ? '0 : to_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/video_cfg_sequencer.sv
// video_cfg_sequencer: applies display config changes on frame events, blanking around preset swaps
module video_cfg_sequencer
  import video_cfg_pkg::*;
#(
  parameter int         BLANK_FRAMES   = 2,
  parameter int         SETTLE_FRAMES  = 2,
  parameter int         TIMEOUT_CYCLES = 2_000_000,
  parameter logic [2:0] RESET_PRESET   = 3'd0,
  parameter logic [31:0] RESET_SW      = 32'h0
) (
  input  logic                clk_vid,
  input  logic                reset,
  input  logic                core_vs,
  input  logic                force_blackout,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [PRESET_W-1:0] req_preset,
  input  logic [SW_W-1:0]     req_video_sw,
  input  logic                req_grayscale,
  output logic [PRESET_W-1:0] video_preset,
  output logic [SW_W-1:0]     video_sw,
  output logic                grayscale_en,
  output logic                blackout_en,
  output logic                busy,
  output logic                cfg_applied
);
  localparam int FW = cnt_w((BLANK_FRAMES > SETTLE_FRAMES) ? BLANK_FRAMES : SETTLE_FRAMES);
  if (BLANK_FRAMES < 1) begin : g_bad_blank
    $error("BLANK_FRAMES must be at least 1");
  end
  if (SETTLE_FRAMES < 1) begin : g_bad_settle
    $error("SETTLE_FRAMES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  state_t        state;
  video_cfg_t    cfg;
  video_cfg_t    pend;
  logic          need_blank;
  logic          seq_blank;
  logic [FW-1:0] frame_cnt;
  logic          frame_evt;
  logic          blank_last;
  logic          settle_last;
  frame_event_gen #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_evt (
    .clk_vid  (clk_vid),
    .reset    (reset),
    .core_vs  (core_vs),
    .run      (state != IDLE),
    .frame_evt(frame_evt)
  );
  assign blank_last = frame_cnt == FW'(BLANK_FRAMES - 1);
  assign settle_last = frame_cnt == FW'(SETTLE_FRAMES - 1);
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign video_preset = cfg.preset;
  assign video_sw = cfg.sw;
  assign grayscale_en = cfg.gray;
  // sequencer: latch request, wait for a frame, optionally blank, apply, settle
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cfg         <= '{preset: RESET_PRESET, sw: RESET_SW, gray: 1'b0};
      pend        <= '0;
      need_blank  <= 1'b0;
      seq_blank   <= 1'b0;
      frame_cnt   <= '0;
      blackout_en <= 1'b0;
      cfg_applied <= 1'b0;
    end else begin
      blackout_en <= seq_blank | force_blackout;
      cfg_applied <= state == APPLY;
      case (state)
        IDLE: if (req_valid) begin
          pend       <= '{preset: req_preset, sw: req_video_sw, gray: req_grayscale};
          need_blank <= req_preset != cfg.preset;
          state      <= WAIT_VS;
        end
        WAIT_VS: if (frame_evt) begin
          state     <= need_blank ? BLANK : APPLY;
          seq_blank <= need_blank;
          frame_cnt <= '0;
        end
        BLANK: if (frame_evt) begin
          state     <= blank_last ? APPLY : BLANK;
          frame_cnt <= blank_last ? '0 : frame_cnt + 1'b1;
        end
        APPLY: begin
          cfg   <= pend;
          state <= need_blank ? SETTLE : IDLE;
        end
        SETTLE: if (frame_evt) begin
          state     <= settle_last ? IDLE : SETTLE;
          seq_blank <= !settle_last;
          frame_cnt <= settle_last ? '0 : frame_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_video_cfg_sequencer.sv
// tb_video_cfg_sequencer: table-driven requests with an apply scoreboard plus corner sequences
module tb_video_cfg_sequencer;
  import video_cfg_pkg::*;
  logic        clk_vid = 1'b0;
  logic        reset = 1'b1;
  logic        core_vs = 1'b0;
  logic        force_blackout = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_grayscale = 1'b0;
  logic [2:0]  req_preset = '0;
  logic [31:0] req_video_sw = '0;
  logic        req_ready, grayscale_en, blackout_en, busy, cfg_applied;
  logic [2:0]  video_preset;
  logic [31:0] video_sw;
  int          n_vec = 0;
  int          n_err = 0;
  typedef struct packed {
    video_cfg_t cfg;
    logic       blank;
  } vec_t;
  vec_t       sb[$];
  vec_t       vt[6];
  video_cfg_t cur;

  always #5 clk_vid = ~clk_vid;

  video_cfg_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk_vid       (clk_vid),
    .reset         (reset),
    .core_vs       (core_vs),
    .force_blackout(force_blackout),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_preset    (req_preset),
    .req_video_sw  (req_video_sw),
    .req_grayscale (req_grayscale),
    .video_preset  (video_preset),
    .video_sw      (video_sw),
    .grayscale_en  (grayscale_en),
    .blackout_en   (blackout_en),
    .busy          (busy),
    .cfg_applied   (cfg_applied)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_vid);
      #1;
    end
  endtask

  task automatic frame();
    core_vs = 1'b1;
    tick();
    core_vs = 1'b0;
  endtask

  task automatic request(input video_cfg_t c);
    req_preset = c.preset;
    req_video_sw = c.sw;
    req_grayscale = c.gray;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // scoreboard: every cfg_applied pulse must match the oldest outstanding request
  always @(negedge clk_vid) begin
    vec_t e;
    if (cfg_applied) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: cfg_applied with no pending request, preset %0d", video_preset);
      end else begin
        e = sb.pop_front();
        chk("sb_cfg", {video_preset, video_sw, grayscale_en}, e.cfg);
        chk("sb_blackout", blackout_en, e.blank);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    request(v.cfg);
    chk("busy_ready", {busy, req_ready}, 2'b10);
    sb.push_back(v);
    tick(3);
    chk("hold_before_vs", {video_preset, video_sw, grayscale_en}, cur);
    frame();
    if (!v.blank) begin
      chk("apply_early", cfg_applied, 1'b0);
      tick();
      chk("apply_lat", {video_preset, video_sw, grayscale_en, req_ready}, {v.cfg, 1'b1});
      chk("apply_pulse", {cfg_applied, blackout_en}, 2'b10);
      tick();
      chk("pulse_end", cfg_applied, 1'b0);
    end else begin
      chk("blk_pre", blackout_en, 1'b0);
      tick();
      chk("blk_rise", blackout_en, 1'b1);
      tick(4);
      frame();
      tick(5);
      frame();
      chk("blank_hold", video_preset, cur.preset);
      tick();
      chk("apply_blank", {video_preset, video_sw, grayscale_en}, v.cfg);
      tick(4);
      frame();
      tick(5);
      frame();
      chk("blk_settle", {blackout_en, req_ready}, 2'b11);
      tick();
      chk("blk_fall", {blackout_en, busy}, 2'b00);
    end
    cur = v.cfg;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    int n;
    vec_t v;
    vt[0] = '{cfg: '{preset: 3'd0, sw: 32'h0000_0021, gray: 1'b1}, blank: 1'b0};
    vt[1] = '{cfg: '{preset: 3'd3, sw: 32'h0000_0021, gray: 1'b1}, blank: 1'b1};
    vt[2] = '{cfg: '{preset: 3'd3, sw: 32'h0000_0021, gray: 1'b1}, blank: 1'b0};
    vt[3] = '{cfg: '{preset: 3'd3, sw: 32'hA5A5_0F0F, gray: 1'b0}, blank: 1'b0};
    vt[4] = '{cfg: '{preset: 3'd0, sw: 32'h0000_0000, gray: 1'b0}, blank: 1'b1};
    vt[5] = '{cfg: '{preset: 3'd6, sw: 32'hFFFF_FFFF, gray: 1'b1}, blank: 1'b1};
    for (int i = 0; i < 4; i++) begin
      core_vs = ~core_vs;
      tick();
    end
    chk("rst_out", {video_preset, video_sw, blackout_en, grayscale_en, cfg_applied}, '0);
    chk("rst_hs", {req_ready, busy}, 2'b10);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core_vs = ~core_vs;
      tick();
    end
    core_vs = 1'b0;
    tick(2);
    chk("post_rst_out", {video_preset, video_sw, blackout_en, cfg_applied}, '0);
    chk("post_rst_hs", {req_ready, busy}, 2'b10);
    cur = '0;
    for (int i = 0; i < 6; i++) run_vec(vt[i]);
    force_blackout = 1'b1;
    chk("force_lat", blackout_en, 1'b0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) force_blackout = 1'b0;
      tick();
      if (i == 0) chk("force_first", blackout_en, 1'b1);
      hi += int'(blackout_en);
    end
    chk("force_cnt", hi, 10);
    chk("force_state", {busy, video_preset, cfg_applied}, {1'b0, 3'd6, 1'b0});
    request('{preset: 3'd7, sw: 32'h0000_1111, gray: 1'b0});
    tick(2);
    frame();
    tick();
    chk("rb_blk", {blackout_en, busy}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("rb_out", {video_preset, video_sw, grayscale_en, blackout_en}, '0);
    chk("rb_hs", {busy, req_ready}, 2'b01);
    tick(2);
    reset = 1'b0;
    cur = '0;
    tick(2);
    run_vec('{cfg: '{preset: 3'd1, sw: 32'h1234_5678, gray: 1'b0}, blank: 1'b1});
    v = '{cfg: '{preset: 3'd5, sw: 32'hDEAD_BEEF, gray: 1'b1}, blank: 1'b1};
    request(v.cfg);
    sb.push_back(v);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    n_vec++;
    if (n < 498 || n > 502) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d expected 500 +-2", n);
    end
    chk("timeout_preset", {video_preset, video_sw}, {3'd5, 32'hDEAD_BEEF});
    tick();
    chk("timeout_unblank", blackout_en, 1'b0);
    tick(2);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
